array_l1_be_sweep: RTL and testbench

//  Parametrised L1 cache storage array: DEPTH entries of WIDTH bits, byte-enable writes,
//  per-entry valid bits and a multi-cycle invalidate sweep FSM with a busy/done handshake.

---
 rtl/array_l1_be_sweep.sv | 66 ++++++
 tb/tb_array_l1_be_sweep.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_l1_be_sweep.sv
// array_l1_be_sweep: byte-enable L1 storage array with invalidate sweep FSM; ARRAY_L1_REGOUT_EN registers the read port
module array_l1_be_sweep #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write,
    input  logic [IDX_W-1:0]   index,
    input  logic [WIDTH/8-1:0] byte_en,
    input  logic [WIDTH-1:0]   datain,
    input  logic               inv_req,
    output logic [WIDTH-1:0]   dataout,
    output logic               valid_out,
    output logic               ready,
    output logic               inv_done
);
    localparam logic [1:0] IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2;
    logic [1:0] state, next;
    logic [IDX_W-1:0] ptr;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    assign ready = state == IDLE;
    assign inv_done = state == DONE;
    always_comb begin
        next = state == IDLE ? (inv_req ? SWEEP : IDLE) :
               state == SWEEP ? (ptr == IDX_W'(DEPTH - 1) ? DONE : SWEEP) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            valid <= '0;
            for (int e = 0; e < DEPTH; e++) data[e] <= '0;
        end else begin
            state <= next;
            if (state == SWEEP) begin
                ptr <= ptr + IDX_W'(1);
                data[ptr] <= '0;
                valid[ptr] <= 1'b0;
            end else if (ready) begin
                if (inv_req) ptr <= '0;
                if (write) begin
                    valid[index] <= 1'b1;
                    for (int b = 0; b < WIDTH / 8; b++)
                        if (byte_en[b]) data[index][8*b +: 8] <= datain[8*b +: 8];
                end
            end
        end
    end
`ifdef ARRAY_L1_REGOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataout <= '0;
            valid_out <= 1'b0;
        end else begin
            dataout <= data[index];
            valid_out <= valid[index];
        end
    end
`else
    assign dataout = data[index];
    assign valid_out = valid[index];
`endif
endmodule

// File: tb/tb_array_l1_be_sweep.sv
// tb_array_l1_be_sweep: randomized self-checking bench against a per-entry byte model
module tb_array_l1_be_sweep;
    logic clk = 0, rst = 1, write = 0, inv_req = 0;
    logic [1:0] index = 0;
    logic [3:0] byte_en = 0;
    logic [31:0] datain = 0, dataout;
    logic valid_out, ready, inv_done;
    logic [31:0] exp_data [4];
    logic [3:0] exp_valid;
    int checks = 0, errors = 0;

    array_l1_be_sweep #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .write(write), .index(index), .byte_en(byte_en),
        .datain(datain), .inv_req(inv_req), .dataout(dataout), .valid_out(valid_out),
        .ready(ready), .inv_done(inv_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic model_write(input int i, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (be[b]) exp_data[i][8*b +: 8] = d[8*b +: 8];
        exp_valid[i] = 1'b1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) exp_data[i] = 0;
        exp_valid = 0;
    endtask

    task automatic do_write(input int i, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        write = 1; index = 2'(i); byte_en = be; datain = d;
        @(posedge clk);
        #1 write = 0;
        model_write(i, be, d);
    endtask

    task automatic peek(input int i, output logic [31:0] d, output logic v);
        index = 2'(i);
`ifdef ARRAY_L1_REGOUT_EN
        @(posedge clk);
`endif
        #1;
        d = dataout;
        v = valid_out;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic v;
        rst = 0;
        model_clear();
        do_write(0, 4'hF, 32'hCAFEF00D);
        @(posedge clk);
        #3 rst = 1;
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        model_clear();
        for (int i = 0; i < 4; i++) begin
            peek(i, d, v);
            checks++;
            if (d !== 32'h0 || v !== 1'b0) begin
                errors++; $display("FAIL reset_entry%0d got %h/%b want 0/0", i, d, v);
            end
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_byte_write();
        logic [31:0] d;
        logic v;
        do_write(2, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        write = 1; index = 2; byte_en = 4'b0101; datain = 32'h11223344;
`ifndef ARRAY_L1_REGOUT_EN
        #1;
        checks++;
        if (dataout !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_old got %h want deadbeef", dataout); end
`endif
        @(posedge clk);
        #1 write = 0;
        model_write(2, 4'b0101, 32'h11223344);
        peek(2, d, v);
        checks++;
        if (d !== 32'hDE22BE44 || v !== 1'b1) begin
            errors++; $display("FAIL byte_write_idx2 got %h/%b want de22be44/1", d, v);
        end
        peek(1, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b0) begin errors++; $display("FAIL byte_write_idx1 got %h/%b want 0/0", d, v); end
    endtask

    task automatic test_read_latency();
        do_write(0, 4'hF, 32'h01234567);
        do_write(2, 4'hF, 32'h89ABCDEF);
        @(negedge clk);
        index = 0;
`ifdef ARRAY_L1_REGOUT_EN
        @(posedge clk);
        #1;
        checks++;
        if (dataout !== exp_data[0]) begin errors++; $display("FAIL lag_idx0 got %h want %h", dataout, exp_data[0]); end
        @(negedge clk);
        index = 2;
        #1;
        checks++;
        if (dataout !== exp_data[0]) begin errors++; $display("FAIL lag_hold got %h want %h", dataout, exp_data[0]); end
        @(posedge clk);
        #1;
        checks++;
        if (dataout !== exp_data[2]) begin errors++; $display("FAIL lag_idx2 got %h want %h", dataout, exp_data[2]); end
`else
        #1;
        checks++;
        if (dataout !== exp_data[0]) begin errors++; $display("FAIL comb_idx0 got %h want %h", dataout, exp_data[0]); end
        index = 2;
        #1;
        checks++;
        if (dataout !== exp_data[2]) begin errors++; $display("FAIL comb_idx2 got %h want %h", dataout, exp_data[2]); end
`endif
    endtask

    task automatic test_sweep();
        logic [31:0] d;
        logic v;
        for (int i = 0; i < 4; i++) do_write(i, 4'hF, $urandom);
        for (int i = 0; i < 4; i++) begin
            peek(i, d, v);
            checks++;
            if (d !== exp_data[i] || v !== 1'b1) begin
                errors++; $display("FAIL fill_idx%0d got %h/%b want %h/1", i, d, v, exp_data[i]);
            end
        end
        @(negedge clk);
        inv_req = 1;
        @(posedge clk);
        #1 inv_req = 0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (ready !== (c == 6) || inv_done !== (c == 5)) begin
                errors++; $display("FAIL sweep_cycle%0d got ready=%b done=%b want ready=%b done=%b",
                                   c, ready, inv_done, c == 6, c == 5);
            end
            if (c < 6) begin @(posedge clk); #1; end
        end
        model_clear();
        for (int i = 0; i < 4; i++) begin
            peek(i, d, v);
            checks++;
            if (d !== 32'h0 || v !== 1'b0) begin errors++; $display("FAIL swept_idx%0d got %h/%b want 0/0", i, d, v); end
        end
    endtask

    task automatic test_write_during_sweep();
        logic [31:0] d;
        logic v;
        bit seen = 0;
        do_write(3, 4'hF, 32'hAAAA5555);
        @(negedge clk);
        inv_req = 1;
        @(posedge clk);
        #1 inv_req = 0;
        @(negedge clk);
        write = 1; index = 3; byte_en = 4'hF; datain = 32'hFFFFFFFF;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1 seen = inv_done;
        end
        write = 0;
        checks++;
        if (!seen) begin errors++; $display("FAIL wds_done got 0 want 1"); end
        @(posedge clk);
        #1;
        model_clear();
        peek(3, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b0) begin errors++; $display("FAIL wds_idx3 got %h/%b want 0/0", d, v); end
    endtask

    task automatic test_write_with_inv();
        logic [31:0] d;
        logic v;
        int cyc = 1;
        bit seen = 0;
        @(negedge clk);
        write = 1; index = 1; byte_en = 4'hF; datain = $urandom; inv_req = 1;
        @(posedge clk);
        #1 write = 0; inv_req = 0;
`ifdef ARRAY_L1_REGOUT_EN
        @(posedge clk);
        #1 cyc = 2;
`endif
        checks++;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL wwi_valid got %b want 1", valid_out); end
        while (cyc < 12 && !seen) begin
            if (inv_done) seen = 1;
            else begin @(posedge clk); #1 cyc++; end
        end
        checks++;
        if (!seen || cyc != 5) begin errors++; $display("FAIL wwi_done_cycle got %0d want 5", cyc); end
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL wwi_ready got %b want 1", ready); end
        model_clear();
        peek(1, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b0) begin errors++; $display("FAIL wwi_idx1 got %h/%b want 0/0", d, v); end
    endtask

    task automatic test_reset_mid_sweep();
        logic [31:0] d;
        logic v;
        int pulses = 0;
        for (int i = 0; i < 4; i++) do_write(i, 4'($urandom), $urandom);
        @(negedge clk);
        inv_req = 1;
        @(posedge clk);
        #1 inv_req = 0;
        @(posedge clk);
        #3 rst = 1;
        #1;
        checks++;
        if (ready !== 1'b1 || inv_done !== 1'b0) begin
            errors++; $display("FAIL rms_state got ready=%b done=%b want 1/0", ready, inv_done);
        end
        @(negedge clk);
        rst = 0;
        model_clear();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 if (inv_done) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rms_no_done got %0d pulses want 0", pulses); end
        for (int i = 0; i < 4; i++) begin
            peek(i, d, v);
            checks++;
            if (d !== 32'h0 || v !== 1'b0) begin errors++; $display("FAIL rms_idx%0d got %h/%b want 0/0", i, d, v); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic v;
        for (int n = 0; n < 60; n++) begin
            int i = $urandom_range(3);
            if ($urandom_range(1)) do_write(i, 4'($urandom), $urandom);
            else begin
                peek(i, d, v);
                checks++;
                if (d !== exp_data[i] || v !== exp_valid[i]) begin
                    errors++; $display("FAIL rand_idx%0d got %h/%b want %h/%b", i, d, v, exp_data[i], exp_valid[i]);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        #2;
        test_reset();
        test_byte_write();
        test_read_latency();
        test_sweep();
        test_write_during_sweep();
        test_write_with_inv();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
